// File: rtl/icache_line_refill.sv
// Instruction-cache line refill engine: fetches one cache line as a burst of
// word reads on the instruction-memory bus and returns it with a one-cycle ack.
module icache_line_refill #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  icache_req_i,
    input  logic [ADDR_WIDTH-1:0] icache_addr_i,
    output logic                  icache_ack_o,
    output logic [LINE_WIDTH-1:0] icache_data_o,
    output logic                  bus_req_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    input  logic                  bus_ack_i,
    input  logic [WORD_WIDTH-1:0] bus_data_i,
    output logic                  busy_o
);

    localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int OFS    = $clog2(LINE_WIDTH / 8);
    localparam int WOFS   = $clog2(WORD_WIDTH / 8);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [BEAT_W-1:0]       beat_r;
    logic [BEAT_W-1:0]       beat_nxt_s;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [ADDR_WIDTH-1:0]   base_nxt_s;
    logic                    kill_r;
    logic                    kill_nxt_s;
    logic                    kill_eff_s;
    logic                    line_we_s;
    logic [LINE_WIDTH-1:0]   line_r;

    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    endfunction

    // Beats stay inside the aligned line, so the sum never carries past OFS.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [BEAT_W-1:0]     beat);
        return base + (ADDR_WIDTH'(beat) << WOFS);
    endfunction

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        base_nxt_s  = base_r;
        kill_nxt_s  = kill_r;
        line_we_s   = 1'b0;
        // The abort decision must see a req drop in the same cycle as the ack.
        kill_eff_s  = kill_r | ~icache_req_i;
        case (state_r)
            ST_IDLE: begin
                if (icache_req_i) begin
                    state_nxt_s = ST_FETCH;
                    base_nxt_s  = line_base(icache_addr_i);
                    beat_nxt_s  = '0;
                    kill_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                kill_nxt_s = kill_eff_s;
                if (bus_ack_i) begin
                    line_we_s = 1'b1;
                    if (kill_eff_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (beat_r == LAST_BEAT) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        beat_nxt_s = beat_r + BEAT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
            base_r  <= '0;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            base_r  <= base_nxt_s;
            kill_r  <= kill_nxt_s;
        end
    end

    // Line assembly buffer; keeps its contents until the next refill's beats land.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_r <= '0;
        end else if (line_we_s) begin
            line_r[beat_r*WORD_WIDTH +: WORD_WIDTH] <= bus_data_i;
        end
    end

    assign icache_ack_o  = (state_r == ST_DONE);
    assign bus_req_o     = (state_r == ST_FETCH);
    assign busy_o        = (state_r != ST_IDLE);
    assign bus_addr_o    = bus_req_o ? beat_addr(base_r, beat_r) : '0;
    assign icache_data_o = line_r;

endmodule
